// File: rtl/slope_conv_ctrl.sv
// slope_conv_ctrl
//   Sequencer for a single-slope ADC. After a start request the ramp DAC is
//   parked at code 0 for SETTLE_CYCLES, then stepped up by one code every
//   STEP_DIV clocks. A comparator edge (capture_en) freezes the current code
//   as the result. If the ramp tops out with no edge, the result is full
//   scale and flagged as over-range. Results are handed to the consumer
//   through a one-entry valid/ready output register. The FSM stalls in DONE
//   when that register is still occupied, so no result is ever dropped.
//
// Ports
//   clk, reset     : clock and synchronous active-high reset
//   start          : conversion request, looked at only in IDLE
//   continuous     : re-arm automatically after each result (sampled in DONE)
//   capture_en     : single-cycle comparator falling-edge pulse (RAMP only)
//   ramp_code      : DAC code
//   ramp_en        : high while ramping
//   busy           : high outside IDLE
//   sample_data    : result code
//   sample_over    : result is a timeout / full-scale result
//   sample_valid   : output register holds an unread result
//   sample_ready   : consumer accepts the result
module slope_conv_ctrl #(
  parameter int CODE_W        = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int STEP_DIV      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              capture_en,
  output logic [CODE_W-1:0] ramp_code,
  output logic              ramp_en,
  output logic              busy,
  output logic [CODE_W-1:0] sample_data,
  output logic              sample_over,
  output logic              sample_valid,
  input  logic              sample_ready
);

  localparam int STEP_W = $clog2(STEP_DIV + 1);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CODE_W-1:0] CODE_MAX  = '1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RAMP   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state;
  logic [SET_W-1:0]  settle_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [CODE_W-1:0] res_data;   // result waiting in DONE for the output register
  logic              res_over;

  logic step_last;
  logic at_max;
  logic load;

  assign step_last = (step_cnt == STEP_LAST);
  assign at_max    = (ramp_code == CODE_MAX);
  // The output register can take the result when it is empty, or when it is
  // being read in this same cycle.
  assign load      = (state == S_DONE) && (!sample_valid || sample_ready);

  assign ramp_en = (state == S_RAMP);
  assign busy    = (state != S_IDLE);

  // Conversion FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      step_cnt   <= '0;
      ramp_code  <= '0;
      res_data   <= '0;
      res_over   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
            ramp_code  <= '0;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == SET_LAST) begin
            state      <= S_RAMP;
            settle_cnt <= '0;
            step_cnt   <= '0;
            ramp_code  <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        S_RAMP: begin
          if (capture_en) begin
            // A comparator edge beats a coincident timeout: the edge really
            // happened at full scale, so it is not an over-range result.
            res_data <= ramp_code;
            res_over <= 1'b0;
            step_cnt <= '0;
            state    <= S_DONE;
          end else if (step_last) begin
            step_cnt <= '0;
            if (at_max) begin
              // Top of the ramp with no edge: report full scale, never wrap.
              res_data <= CODE_MAX;
              res_over <= 1'b1;
              state    <= S_DONE;
            end else begin
              ramp_code <= ramp_code + 1'b1;
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end

        S_DONE: begin
          // ramp_code holds its final value while stalled here.
          if (load) begin
            ramp_code  <= '0;
            settle_cnt <= '0;
            state      <= continuous ? S_SETTLE : S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // One-entry output register
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_data  <= '0;
      sample_over  <= 1'b0;
      sample_valid <= 1'b0;
    end else if (load) begin
      sample_data  <= res_data;
      sample_over  <= res_over;
      sample_valid <= 1'b1;
    end else if (sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: doc/slope_conv_ctrl.md
SLOPE_CONV_CTRL -- requirements
Module: slope_conv_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, default 8: width of the ramp DAC code and the result.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16: number of cycles the ramp is held at 0 before each ramp starts; legal range >= 1.
REQ-003 SHALL have parameter STEP_DIV, default 1: number of clocks per ramp code step; legal range >= 1.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-007 SHALL have port continuous, input, 1 bit: when 1, the block auto-restarts after each result is loaded.
REQ-008 SHALL have port capture_en, input, 1 bit: single-cycle pulse from the comparator edge detector, marking the comparator falling edge.
REQ-009 SHALL have port ramp_code, output, CODE_W bits: code driven to the ramp DAC.
REQ-010 SHALL have port ramp_en, output, 1 bit: 1 only in state RAMP.
REQ-011 SHALL have port busy, output, 1 bit: 1 in every state except IDLE.
REQ-012 SHALL have port sample_data, output, CODE_W bits: converted result.
REQ-013 SHALL have port sample_over, output, 1 bit: the result is a timeout (full-scale) result, qualified by sample_valid.
REQ-014 SHALL have port sample_valid, output, 1 bit: output register holds an unread result.
REQ-015 SHALL have port sample_ready, input, 1 bit: consumer accepts the result.

Function
REQ-016 SHALL implement the states IDLE, SETTLE, RAMP and DONE.
REQ-017 IDLE: start=1 -> SETTLE on the next edge; ramp_code = 0.
REQ-018 SETTLE: ramp_code = 0; the block SHALL stay exactly SETTLE_CYCLES cycles, then go to RAMP with ramp_code = 0 and the step counter = 0.
REQ-019 RAMP: ramp_code SHALL increment by 1 once every STEP_DIV cycles; the first increment occurs after STEP_DIV cycles spent at code 0.
REQ-020 RAMP with capture_en=1: the block SHALL latch the current ramp_code as the result with over=0, then go to DONE on the next edge.
REQ-021 Timeout: ramp_code = all-ones, final step cycle, capture_en=0 -> result = all-ones, over=1, then DONE; ramp_code SHALL never wrap to 0.
REQ-022 Capture on the same cycle as the timeout: the capture SHALL win (result = all-ones, over=0).
REQ-023 capture_en SHALL be ignored in IDLE, SETTLE and DONE.
REQ-024 In DONE, ramp_code SHALL hold its last value and ramp_en = 0.
REQ-025 DONE, loading the result: the pending result SHALL be loaded into sample_data/sample_over with sample_valid=1 when sample_valid=0, or when sample_valid=1 and sample_ready=1 in the same cycle.
REQ-026 DONE, after the load: continuous=1 -> SETTLE; otherwise -> IDLE.
REQ-027 DONE, no load possible: the block SHALL stall in DONE, with no result dropped or overwritten.
REQ-028 sample_valid SHALL clear on any cycle with sample_ready=1 and no new load.
REQ-029 sample_data and sample_over SHALL be stable while sample_valid=1 and sample_ready=0.
REQ-030 The start-to-valid latency SHALL be 1 + SETTLE_CYCLES + (capture cycle index in RAMP) + 1 + 1 cycles when the output register is free.
REQ-031 The continuous input SHALL be sampled only in DONE; start SHALL be ignored while busy=1.
REQ-032 The step counter SHALL be ceil(log2(STEP_DIV+1)) bits wide, and the settle counter SHALL be sized the same way from SETTLE_CYCLES; neither counter SHALL overflow.

Reset
REQ-033 reset=1 SHALL force on the next edge, regardless of state: state = IDLE, ramp_code = 0, ramp_en = 0, busy = 0, sample_data = 0, sample_over = 0, sample_valid = 0, and both internal counters = 0.
REQ-034 A reset during SETTLE, RAMP or DONE SHALL abort the conversion, with no partial result presented.
REQ-035 reset SHALL take priority over start, capture_en and sample_ready.

Verification (CODE_W=8, SETTLE_CYCLES=4, STEP_DIV=1 unless stated)
REQ-036 Start pulse, capture_en pulsed when ramp_code=0x5A, sample_ready=1 -> sample_data=0x5A, sample_over=0, sample_valid 1 cycle; then IDLE, busy=0.
REQ-037 Start, capture_en never asserted -> ramp reaches 0xFF and holds; sample_data=0xFF, sample_over=1; ramp_code never returns to 0 before DONE.
REQ-038 continuous=1, sample_ready=0, two captures at 0x10 -> first result stays on the output; the block stalls in DONE with ramp_code=0x10; raising sample_ready delivers the 0x10 results in order, with no loss.
REQ-039 STEP_DIV=3, capture when ramp_code=2 -> capture occurs on RAMP cycle 6..8; result=0x02; each code held exactly 3 cycles.
REQ-040 reset asserted mid-RAMP at code 0x30 -> next cycle all outputs at reset values; a capture_en in the following cycles produces no result.
REQ-041 capture_en pulses in IDLE and SETTLE, plus start asserted while busy -> no result generated and no extra conversion queued.
